// File: rtl/arb_mux_rr.sv
// N-to-1 round-robin arbitrating mux with one registered valid/ready output stage.
// Optional packet lock (in_last/out_last) is enabled by defining ARB_MUX_LAST_LOCK_EN.
module arb_mux_rr #(
  parameter  int size = 32,
  parameter  int N    = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_valid,
  input  logic [N*size-1:0] in_data,
  output logic [N-1:0]      in_ready,
`ifdef ARB_MUX_LAST_LOCK_EN
  input  logic [N-1:0]      in_last,
  output logic              out_last,
`endif
  output logic              out_valid,
  output logic [size-1:0]   out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] win;
  logic [SELW-1:0] ptr_nxt;
  logic [SELW-1:0] scan_idx;
  logic            found;
  logic [size-1:0] win_data;
  logic            load;
  logic            any_valid;
  logic            transfer;
`ifdef ARB_MUX_LAST_LOCK_EN
  logic            locked;
  logic [SELW-1:0] lock_sel;
`endif

  assign load      = !out_valid || out_ready;
  assign any_valid = |in_valid;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win      = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = SELW'((int'(ptr) + k) % N);
      if (!found && in_valid[scan_idx]) begin
        win   = scan_idx;
        found = 1'b1;
      end
    end
`ifdef ARB_MUX_LAST_LOCK_EN
    if (locked) win = lock_sel;
`endif
  end

  always_comb begin
    win_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (win == SELW'(i)) begin
        win_data    = in_data[i*size +: size];
        in_ready[i] = rst && load && any_valid;
      end
    end
  end

  assign transfer = |(in_valid & in_ready);
  assign ptr_nxt  = (win == SELW'(N - 1)) ? '0 : SELW'(win + 1'b1);

  always_ff @(posedge clk) begin
    // NOTE: the data register is reset too, because its reset value of 0 is architecturally visible.
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef ARB_MUX_LAST_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_sel  <= '0;
`endif
    end else if (load) begin
      out_valid <= transfer;
      if (transfer) begin
        out_data <= win_data;
        out_sel  <= win;
`ifdef ARB_MUX_LAST_LOCK_EN
        out_last <= in_last[win];
        locked   <= !in_last[win];
        lock_sel <= win;
        // Mid-packet beats keep the pointer; only the closing beat advances it.
        if (in_last[win]) ptr <= ptr_nxt;
`else
        ptr      <= ptr_nxt;
`endif
      end
    end
  end

endmodule
